uart_cmd_dispatch: RTL and testbench

- Consumes the 32-bit address/data write commands decoded from the host UART link (one-cycle write-enable pulses) and buffers them in a small FIFO.
- Routes each command either to a per-core local memory write port through a valid/ready handshake, or to block-local control registers (core reset, start pulse, error clear).
- Sits between the UART packet receiver and the manycore memory-load fabric.
- Decouples the bursty host stream from memory-port backpressure and counts dropped commands.

---
 rtl/uart_cmd_dispatch_if.sv | 26 ++
 rtl/uart_cmd_dispatch.sv | 129 ++++++++++++
 tb/tb_uart_cmd_dispatch.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_dispatch_if.sv
// Command-in / memory-write-out bundle for the UART command dispatcher.
// master = the surrounding fabric, slave = the dispatcher.
interface uart_cmd_dispatch_if #(
  parameter int CORE_ID_BITS  = 4,
  parameter int MEM_ADDR_BITS = 12
) ();
  logic [31:0]              in_addr;
  logic [31:0]              in_data;
  logic                     in_we;
  logic                     mem_valid;
  logic                     mem_ready;
  logic                     mem_broadcast;
  logic [CORE_ID_BITS-1:0]  mem_core_id;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic [31:0]              mem_data;

  modport master (
    output in_addr, in_data, in_we, mem_ready,
    input  mem_valid, mem_broadcast, mem_core_id, mem_addr, mem_data
  );

  modport slave (
    input  in_addr, in_data, in_we, mem_ready,
    output mem_valid, mem_broadcast, mem_core_id, mem_addr, mem_data
  );
endinterface

// File: rtl/uart_cmd_dispatch.sv
// Buffers host write commands in a FIFO and dispatches them in order to a
// valid/ready memory write port or to local control registers; counts drops.
module uart_cmd_dispatch #(
  parameter int FIFO_DEPTH_BITS = 3,
  parameter int CORE_ID_BITS    = 4,
  parameter int MEM_ADDR_BITS   = 12
) (
  input  logic                clk,
  input  logic                reset,
  uart_cmd_dispatch_if.slave  bus,
  output logic                ctrl_core_reset,
  output logic                ctrl_start,
  output logic                fifo_overflow,
  output logic [7:0]          drop_count
);

  localparam int AW    = FIFO_DEPTH_BITS;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [31:0] fifo_addr [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic                     mem_valid_q;
  logic                     mem_broadcast_q;
  logic [CORE_ID_BITS-1:0]  mem_core_id_q;
  logic [MEM_ADDR_BITS-1:0] mem_addr_q;
  logic [31:0]              mem_data_q;

  logic        push;
  logic        drop;
  logic        pop;
  logic        stage_free;
  logic        head_ctrl;
  logic        ctrl_clear;
  logic [31:0] head_addr;
  logic [31:0] head_data;
  logic        unused_head_bits;

  always_comb begin
    push       = bus.in_we && (count < FULL_COUNT);
    drop       = bus.in_we && (count == FULL_COUNT);
    stage_free = !mem_valid_q || bus.mem_ready;
    pop        = (count != '0) && stage_free;
    head_addr  = fifo_addr[rd_ptr];
    head_data  = fifo_data[rd_ptr];
    head_ctrl  = head_addr[31];
    ctrl_clear = pop && head_ctrl && (head_addr[3:0] == 4'd2);
  end

  // Only a subset of the address bits are decoded; the rest are ignored.
  assign unused_head_bits = ^head_addr;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.in_addr;
      fifo_data[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      mem_valid_q     <= 1'b0;
      mem_broadcast_q <= 1'b0;
      mem_core_id_q   <= '0;
      mem_addr_q      <= '0;
      mem_data_q      <= '0;
      ctrl_core_reset <= 1'b1;
      ctrl_start      <= 1'b0;
      fifo_overflow   <= 1'b0;
      drop_count      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (stage_free) begin
        if (pop && !head_ctrl) begin
          mem_valid_q     <= 1'b1;
          mem_broadcast_q <= head_addr[30];
          mem_core_id_q   <= head_addr[MEM_ADDR_BITS+CORE_ID_BITS-1:MEM_ADDR_BITS];
          mem_addr_q      <= head_addr[MEM_ADDR_BITS-1:0];
          mem_data_q      <= head_data;
        end else begin
          mem_valid_q <= 1'b0;
        end
      end

      ctrl_start <= 1'b0;
      if (pop && head_ctrl) begin
        case (head_addr[3:0])
          4'd0:    ctrl_core_reset <= head_data[0];
          4'd1:    ctrl_start      <= head_data[0];
          default: ;
        endcase
      end

      // A drop coinciding with a clear leaves exactly that one drop recorded.
      if (drop) begin
        fifo_overflow <= 1'b1;
        if (ctrl_clear)
          drop_count <= 8'd1;
        else if (drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end else if (ctrl_clear) begin
        fifo_overflow <= 1'b0;
        drop_count    <= 8'd0;
      end
    end
  end

  assign bus.mem_valid     = mem_valid_q;
  assign bus.mem_broadcast = mem_broadcast_q;
  assign bus.mem_core_id   = mem_core_id_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_data      = mem_data_q;

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// Scoreboard bench for uart_cmd_dispatch: directed stimulus queues expected
// memory writes; a negedge monitor pops and compares each accepted write.
module tb_uart_cmd_dispatch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ctrl_core_reset;
  logic       ctrl_start;
  logic       fifo_overflow;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  uart_cmd_dispatch_if bus ();

  uart_cmd_dispatch dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .ctrl_core_reset(ctrl_core_reset),
    .ctrl_start     (ctrl_start),
    .fifo_overflow  (fifo_overflow),
    .drop_count     (drop_count)
  );

  typedef struct packed {
    logic        bc;
    logic [3:0]  core;
    logic [11:0] addr;
    logic [31:0] data;
  } mem_t;

  mem_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   delivered = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic mem_t mw(logic bc, logic [3:0] core, logic [11:0] a, logic [31:0] d);
    mem_t m;
    m.bc = bc; m.core = core; m.addr = a; m.data = d;
    return m;
  endfunction

  // Monitor: compares every accepted write and checks holds during stalls.
  mem_t mon_prev;
  logic mon_prev_stall = 1'b0;
  always @(negedge clk) begin : monitor
    mem_t cur;
    mem_t e;
    cur = mw(bus.mem_broadcast, bus.mem_core_id, bus.mem_addr, bus.mem_data);
    if (reset) begin
      mon_prev_stall = 1'b0;
    end else begin
      if (mon_prev_stall) begin
        check("stall_valid_held", 64'(bus.mem_valid), 64'd1);
        check("stall_payload_held", 64'(cur), 64'(mon_prev));
      end
      if (bus.mem_valid && bus.mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem_write: got 0x%0h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          check("mem_broadcast", 64'(cur.bc), 64'(e.bc));
          if (!e.bc) check("mem_core_id", 64'(cur.core), 64'(e.core));
          check("mem_addr", 64'(cur.addr), 64'(e.addr));
          check("mem_data", 64'(cur.data), 64'(e.data));
          delivered++;
        end
      end
      mon_prev_stall = bus.mem_valid && !bus.mem_ready;
      mon_prev       = cur;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered and left at posedge+1: strobe is sampled at the next edge.
  task automatic drive(logic [31:0] a, logic [31:0] d);
    bus.in_addr = a;
    bus.in_data = d;
    bus.in_we   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int gaps;
    int starts;
    int vcnt;

    bus.in_addr   = '0;
    bus.in_data   = '0;
    bus.in_we     = 1'b0;
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    check("rst_core_reset", 64'(ctrl_core_reset), 64'd1);
    check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_overflow", 64'(fifo_overflow), 64'd0);
    check("rst_start", 64'(ctrl_start), 64'd0);
    check("rst_mem_data", 64'(bus.mem_data), 64'd0);

    // Streaming with the sink always ready
    bus.mem_ready = 1'b1;
    exp_q.push_back(mw(1'b0, 4'd3, 12'h004, 32'h11));
    exp_q.push_back(mw(1'b0, 4'd5, 12'h010, 32'h22));
    exp_q.push_back(mw(1'b1, 4'd0, 12'h008, 32'h33));
    drive(32'h0000_3004, 32'h11);
    check("latency_not_early", 64'(bus.mem_valid), 64'd0);
    drive(32'h0000_5010, 32'h22);
    check("latency_first_valid", 64'(bus.mem_valid), 64'd1);
    drive(32'h4000_0008, 32'h33);
    check("stream_valid_2", 64'(bus.mem_valid), 64'd1);
    tick(1);
    check("stream_valid_3", 64'(bus.mem_valid), 64'd1);
    tick(3);
    check("stream_delivered", 64'(delivered), 64'd3);

    // Backpressure: 1 in the stage, 8 in the FIFO, the 10th dropped
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(mw(1'b0, 4'(i), 12'(32'h100 + 32'(i)), 32'hB000 + 32'(i)));
      drive((32'(i) << 12) | (32'h100 + 32'(i)), 32'hB000 + 32'(i));
    end
    check("bp_overflow", 64'(fifo_overflow), 64'd1);
    check("bp_drop_count", 64'(drop_count), 64'd1);
    tick(3);
    d0 = delivered;
    gaps = 0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (!bus.mem_valid) gaps++;
    end
    @(negedge clk);
    check("bp_drained_valid", 64'(bus.mem_valid), 64'd0);
    @(posedge clk);
    #1;
    check("bp_burst_gaps", 64'(gaps), 64'd0);
    check("bp_delivered", 64'(delivered - d0), 64'd9);

    // Control registers
    drive(32'h8000_0000, 32'h0);
    check("core_reset_not_early", 64'(ctrl_core_reset), 64'd1);
    tick(1);
    check("core_reset_cleared", 64'(ctrl_core_reset), 64'd0);
    drive(32'h8000_0001, 32'h1);
    check("start_not_early", 64'(ctrl_start), 64'd0);
    tick(1);
    check("start_pulse", 64'(ctrl_start), 64'd1);
    tick(1);
    check("start_one_cycle", 64'(ctrl_start), 64'd0);
    drive(32'h8000_0002, 32'h0);
    tick(1);
    check("clear_overflow", 64'(fifo_overflow), 64'd0);
    check("clear_drop_count", 64'(drop_count), 64'd0);

    // Ordering: control waits behind a stalled memory write
    bus.mem_ready = 1'b0;
    exp_q.push_back(mw(1'b0, 4'd1, 12'h020, 32'hAA));
    drive(32'h0000_1020, 32'hAA);
    drive(32'h8000_0001, 32'h1);
    starts = 0;
    repeat (5) begin
      tick(1);
      if (ctrl_start) starts++;
    end
    check("order_start_held", 64'(starts), 64'd0);
    bus.mem_ready = 1'b1;
    tick(1);
    check("order_start_after_accept", 64'(ctrl_start), 64'd1);
    starts = 1;
    repeat (3) begin
      tick(1);
      if (ctrl_start) starts++;
    end
    check("order_start_pulses", 64'(starts), 64'd1);

    // Saturation: 9 accepted, 291 dropped
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 300; i++)
      drive(32'h0000_2000 | 32'(i), 32'(i));
    check("sat_drop_count", 64'(drop_count), 64'd255);
    check("sat_overflow", 64'(fifo_overflow), 64'd1);

    // Reset while the stream is still arriving
    bus.in_addr = 32'h0000_2400;
    bus.in_data = 32'h5;
    bus.in_we   = 1'b1;
    reset       = 1'b1;
    tick(1);
    reset     = 1'b0;
    bus.in_we = 1'b0;
    check("midrst_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("midrst_drop_count", 64'(drop_count), 64'd0);
    check("midrst_overflow", 64'(fifo_overflow), 64'd0);
    check("midrst_core_reset", 64'(ctrl_core_reset), 64'd1);
    bus.mem_ready = 1'b1;
    vcnt = 0;
    repeat (5) begin
      tick(1);
      if (bus.mem_valid) vcnt++;
    end
    check("midrst_fifo_empty", 64'(vcnt), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
